// File: rtl/windowed_reg_file_pkg.sv
// Shared constants, index types and window-base encodings for windowed_reg_file.
package windowed_reg_file_pkg;

   localparam int DATA_W   = 16;
   localparam int NUM_PHYS = 8;
   localparam int LOG_AW   = 2;
   localparam int WND_W    = 3;

   typedef logic [WND_W-1:0]  phys_idx_t;
   typedef logic [LOG_AW-1:0] log_idx_t;

   // Window bases as issued by the control unit; always even.
   localparam phys_idx_t WND_0 = 3'b000;
   localparam phys_idx_t WND_1 = 3'b010;
   localparam phys_idx_t WND_2 = 3'b100;
   localparam phys_idx_t WND_3 = 3'b110;

   // Clears bit 0 so an odd requested base rounds down to its window.
   localparam phys_idx_t WND_ALIGN = {{(WND_W-1){1'b1}}, 1'b0};

endpackage

// File: rtl/windowed_reg_file_wnd_addr_map.sv
// Logical-to-physical register index: window base plus logical index, wrapping mod NUM_PHYS.
module wnd_addr_map
   import windowed_reg_file_pkg::*;
(
   input  logic [WND_W-1:0]  base_i,
   input  logic [LOG_AW-1:0] log_i,
   output logic [WND_W-1:0]  phys_o
);

   assign phys_o = base_i + phys_idx_t'(log_i);

endmodule

// File: rtl/windowed_reg_file.sv
// 8 x 16-bit windowed register file: 4-register logical window on an even base, 2R/1W.
// Define WRF_BYPASS_EN to forward same-cycle write data onto a matching read port.
module windowed_reg_file
   import windowed_reg_file_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              wnd_we,
   input  logic [WND_W-1:0]  rf_wnd,
   input  logic [LOG_AW-1:0] rd_addr0,
   input  logic [LOG_AW-1:0] rd_addr1,
   output logic [DATA_W-1:0] rd_data0,
   output logic [DATA_W-1:0] rd_data1,
   input  logic              wr_en,
   input  logic [LOG_AW-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [WND_W-1:0]  cur_wnd
);

   logic [WND_W-1:0]  cur_wnd_q;
   logic [WND_W-1:0]  cur_wnd_d;
   logic [DATA_W-1:0] reg_q [NUM_PHYS];

   logic [WND_W-1:0]  rd_phys0;
   logic [WND_W-1:0]  rd_phys1;
   logic [WND_W-1:0]  wr_phys;

   // All three ports map through the current base, so a write on a window-change edge uses the old window.
   wnd_addr_map u_map_rd0 (.base_i(cur_wnd_q), .log_i(rd_addr0), .phys_o(rd_phys0));
   wnd_addr_map u_map_rd1 (.base_i(cur_wnd_q), .log_i(rd_addr1), .phys_o(rd_phys1));
   wnd_addr_map u_map_wr  (.base_i(cur_wnd_q), .log_i(wr_addr),  .phys_o(wr_phys));

   always_comb begin
      cur_wnd_d = cur_wnd_q;
      if (wnd_we) begin
         cur_wnd_d = rf_wnd & WND_ALIGN;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_wnd_q <= WND_0;
      end else begin
         cur_wnd_q <= cur_wnd_d;
      end
   end

   for (genvar gi = 0; gi < NUM_PHYS; gi++) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            reg_q[gi] <= '0;
         end else if (wr_en && (wr_phys == phys_idx_t'(gi))) begin
            reg_q[gi] <= wr_data;
         end
      end
   end

`ifdef WRF_BYPASS_EN
   assign rd_data0 = (wr_en && (wr_phys == rd_phys0)) ? wr_data : reg_q[rd_phys0];
   assign rd_data1 = (wr_en && (wr_phys == rd_phys1)) ? wr_data : reg_q[rd_phys1];
`else
   assign rd_data0 = reg_q[rd_phys0];
   assign rd_data1 = reg_q[rd_phys1];
`endif

   assign cur_wnd = cur_wnd_q;

endmodule

// File: tb/tb_windowed_reg_file.sv
// Scoreboard bench for windowed_reg_file: reference array model plus directed and random cycles.
module tb_windowed_reg_file;
   import windowed_reg_file_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              wnd_we;
   logic [WND_W-1:0]  rf_wnd;
   logic [LOG_AW-1:0] rd_addr0;
   logic [LOG_AW-1:0] rd_addr1;
   logic [DATA_W-1:0] rd_data0;
   logic [DATA_W-1:0] rd_data1;
   logic              wr_en;
   logic [LOG_AW-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [WND_W-1:0]  cur_wnd;

   windowed_reg_file dut (
      .clk(clk), .rst(rst), .wnd_we(wnd_we), .rf_wnd(rf_wnd),
      .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
      .rd_data0(rd_data0), .rd_data1(rd_data1),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .cur_wnd(cur_wnd)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      int          sel;   // 0: rd_data0, 1: rd_data1, 2: cur_wnd
      logic [15:0] exp;
   } sb_t;

   sb_t         sb_q[$];
   int          vectors     = 0;
   int          miscompares = 0;
   logic [15:0] mdl [8];
   int          mdl_wnd;

   task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end else begin
         $display("ok   %s: %h", tag, obs);
      end
   endtask

   task automatic push(input string tag, input int sel, input logic [15:0] exp);
      sb_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      sb_q.push_back(e);
   endtask

   task automatic drain();
      sb_t         e;
      logic [15:0] obs;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         case (e.sel)
            0:       obs = rd_data0;
            1:       obs = rd_data1;
            default: obs = {13'b0, cur_wnd};
         endcase
         check_val(e.tag, obs, e.exp);
      end
   endtask

   function automatic logic [15:0] mdl_rd(input int l);
      return mdl[(mdl_wnd + l) % 8];
   endfunction

   // One clock edge with the given write / window-select inputs; model updated at the edge.
   task automatic cyc(input bit we, input int wa, input logic [15:0] wd, input bit wwe, input int wnd);
      wr_en   = we;
      wr_addr = LOG_AW'(wa);
      wr_data = wd;
      wnd_we  = wwe;
      rf_wnd  = WND_W'(wnd);
      @(posedge clk);
      if (we)  mdl[(mdl_wnd + wa) % 8] = wd;
      if (wwe) mdl_wnd = (wnd % 8) / 2 * 2;
      #1;
      wr_en  = 1'b0;
      wnd_we = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input int a0, input int a1);
      rd_addr0 = LOG_AW'(a0);
      rd_addr1 = LOG_AW'(a1);
      #1;
      push($sformatf("%s rd0[R%0d]", tag, a0), 0, mdl_rd(a0));
      push($sformatf("%s rd1[R%0d]", tag, a1), 1, mdl_rd(a1));
      push($sformatf("%s cur_wnd", tag), 2, 16'(mdl_wnd));
      drain();
   endtask

   task automatic mdl_clear();
      for (int i = 0; i < 8; i++) mdl[i] = '0;
      mdl_wnd = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; wnd_we = 1'b0; rf_wnd = '0; wr_en = 1'b0;
      wr_addr = '0; wr_data = '0; rd_addr0 = '0; rd_addr1 = '0;
      mdl_clear();
      #2;
      rd_chk("reset", 0, 3);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // Window 0 fill, then move to window 1 to see the overlap.
      cyc(1, 0, 16'h1111, 0, 0);
      cyc(1, 1, 16'h2222, 0, 0);
      cyc(1, 2, 16'h3333, 0, 0);
      cyc(1, 3, 16'h4444, 0, 0);
      rd_chk("wnd0", 0, 1);
      rd_chk("wnd0", 2, 3);
      cyc(0, 0, 16'h0, 1, WND_1);
      rd_addr0 = 2'd0; rd_addr1 = 2'd1; #1;
      push("overlap R0", 0, 16'h3333);
      push("overlap R1", 1, 16'h4444);
      push("overlap cur_wnd", 2, 16'h0002);
      drain();

      // Odd window requests round down.
      cyc(0, 0, 16'h0, 1, 3'b101);
      push("odd 101 cur_wnd", 2, 16'h0004);
      drain();
      cyc(0, 0, 16'h0, 1, 3'b011);
      push("odd 011 cur_wnd", 2, 16'h0002);
      drain();

      // Wrap-around from window 6 into phys 0/1.
      cyc(0, 0, 16'h0, 1, WND_3);
      cyc(1, 2, 16'hBEEF, 0, 0);
      rd_chk("wrap", 2, 3);
      cyc(0, 0, 16'h0, 1, WND_0);
      rd_addr0 = 2'd0; rd_addr1 = 2'd1; #1;
      push("wrap R0", 0, 16'hBEEF);
      push("wrap R1", 1, 16'h2222);
      drain();

      // Write and window change on the same edge: write uses the old base.
      cyc(1, 3, 16'hA5A5, 1, WND_2);
      rd_addr0 = 2'd3; rd_addr1 = 2'd3; #1;
      push("same-edge R3@wnd4", 0, 16'h0000);
      push("same-edge R3@wnd4 p1", 1, 16'h0000);
      push("same-edge cur_wnd", 2, 16'h0004);
      drain();
      cyc(0, 0, 16'h0, 1, WND_0);
      rd_chk("same-edge back", 3, 3);

      // Enables low: X on address/window inputs must not disturb state.
      wr_addr = 'x; rf_wnd = 'x; wr_data = 16'hDEAD;
      @(posedge clk); #1;
      rd_chk("idle", 0, 3);

      // Random traffic against the model.
      for (int i = 0; i < 20; i++) begin
         cyc($urandom_range(0, 1) == 1, int'($urandom_range(0, 3)), 16'($urandom),
             $urandom_range(0, 3) == 0, int'($urandom_range(0, 7)));
         rd_chk($sformatf("rand%0d", i), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

      // Read-during-write on R1.
      cyc(0, 0, 16'h0, 1, WND_0);
      cyc(1, 1, 16'h0001, 0, 0);
      wr_en = 1'b1; wr_addr = 2'd1; wr_data = 16'h00FF;
      rd_addr0 = 2'd1; #1;
`ifdef WRF_BYPASS_EN
      push("rdw before edge", 0, 16'h00FF);
`else
      push("rdw before edge", 0, 16'h0001);
`endif
      drain();
      @(posedge clk);
      mdl[(mdl_wnd + 1) % 8] = 16'h00FF;
      #1; wr_en = 1'b0; #1;
      push("rdw after edge", 0, 16'h00FF);
      drain();

      // Asynchronous reset mid-cycle with a write pending.
      cyc(0, 0, 16'h0, 1, WND_2);
      cyc(1, 0, 16'h7777, 0, 0);
      wr_en = 1'b1; wr_addr = 2'd1; wr_data = 16'h1234; wnd_we = 1'b1; rf_wnd = WND_3;
      #2;
      rst = 1'b1;
      #1;
      mdl_clear();
      rd_chk("async rst", 0, 1);
      @(posedge clk); #1;
      rst = 1'b0; wr_en = 1'b0; wnd_we = 1'b0;
      rd_chk("post rst", 1, 2);
      rd_chk("post rst", 3, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
